imsic_msi_sequencer: RTL



---
 rtl/imsic_msi_pkg.sv | 23 ++
 rtl/imsic_msi_rr_arb.sv | 45 ++++
 rtl/imsic_msi_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/imsic_msi_pkg.sv
// imsic_msi_pkg: shared state encoding and constants for the IMSIC MSI sequencer.
package imsic_msi_pkg;

   // Sequencer states: one write transaction is ISSUE -> WAIT_BUSY -> WAIT_DONE.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } msi_state_e;

   // Each interrupt file occupies one 4 KiB page.
   localparam int unsigned PAGE_SHIFT = 12;

   // Width of an external interrupt identity.
   localparam int unsigned EIID_W = 11;

   // Index width that never collapses to zero bits, so a single-entry vector still gets a port.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/imsic_msi_rr_arb.sv
// imsic_msi_rr_arb: round-robin arbiter; the search for a requester starts at ptr_i and wraps.
module imsic_msi_rr_arb
   import imsic_msi_pkg::*;
#(
   parameter int unsigned  NR_REQ = 4,
   localparam int unsigned IDX_W  = idx_width(NR_REQ)
) (
   input  logic [NR_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NR_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              any_o
);

   logic [2*NR_REQ-1:0] dbl;
   logic [NR_REQ-1:0]   rot;
   int unsigned         ofs;
   int unsigned         win;

   // Rotating the request vector puts the pointer position at bit 0.
   assign dbl = {valid_i, valid_i} >> ptr_i;
   assign rot = dbl[NR_REQ-1:0];

   // Lowest set bit of the rotated vector is the winner; map its offset back to an index.
   always_comb begin
      any_o = 1'b0;
      ofs   = 0;
      for (int i = NR_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            any_o = 1'b1;
            ofs   = unsigned'(i);
         end
      end
      win = 32'(ptr_i) + ofs;
      if (win >= NR_REQ) begin
         win = win - NR_REQ;
      end
      idx_o   = IDX_W'(win);
      grant_o = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         grant_o[i] = any_o && (win == unsigned'(i));
      end
   end

endmodule

// File: rtl/imsic_msi_sequencer.sv
// imsic_msi_sequencer: arbitrates MSI requests and turns each legal one into a single
// AXI-lite write of the EIID to the page of the target IMSIC interrupt file.
module imsic_msi_sequencer
   import imsic_msi_pkg::*;
#(
   parameter int unsigned  NR_REQ                = 4,
   parameter int unsigned  NR_IMSICS             = 1,
   parameter int unsigned  NR_VS_FILES_PER_IMSIC = 0,
   parameter int unsigned  NR_SRC                = 30,
   parameter int unsigned  AXI_ADDR_WIDTH        = 64,
   parameter int unsigned  AXI_DATA_WIDTH        = 64,
   parameter logic [63:0]  IMSIC_BASE            = 64'h2400_0000,
   parameter int unsigned  TIMEOUT               = 255,
   localparam int unsigned NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
   localparam int unsigned INTP_FILE_LEN         = $clog2(NR_INTP_FILES),
   localparam int unsigned HART_W                = idx_width(NR_IMSICS)
) (
   input  logic                                    i_clk,
   input  logic                                    ni_rst,
   input  logic [NR_REQ-1:0]                       i_req_valid,
   output logic [NR_REQ-1:0]                       o_req_ready,
   input  logic [NR_REQ-1:0][HART_W-1:0]           i_req_hart,
   input  logic [NR_REQ-1:0][INTP_FILE_LEN-1:0]    i_req_file,
   input  logic [NR_REQ-1:0][EIID_W-1:0]           i_req_eiid,
   output logic                                    o_wr_start,
   output logic [AXI_ADDR_WIDTH-1:0]               o_wr_addr,
   output logic [AXI_DATA_WIDTH-1:0]               o_wr_data,
   input  logic                                    i_wr_busy,
   output logic                                    o_drop,
   output logic                                    o_timeout,
   output logic                                    o_busy,
   output logic [15:0]                             o_msi_cnt
);

   localparam int unsigned     IDX_W   = idx_width(NR_REQ);
   localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   msi_state_e                state_q, state_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
   logic [WD_W-1:0]           wdog_q, wdog_d;
   logic [15:0]               cnt_q, cnt_d;
   logic                      drop_q, drop_d;
   logic                      timeout_q, timeout_d;

   logic [NR_REQ-1:0]         arb_grant;
   logic [IDX_W-1:0]          arb_idx;
   logic                      arb_any;
   logic                      accept;
   logic                      req_legal;
   logic                      fire_timeout;
   logic                      finish;

   logic [HART_W-1:0]         sel_hart;
   logic [INTP_FILE_LEN-1:0]  sel_file;
   logic [EIID_W-1:0]         sel_eiid;
   logic [AXI_ADDR_WIDTH-1:0] tgt_addr;

   imsic_msi_rr_arb #(
      .NR_REQ (NR_REQ)
   ) u_arb (
      .valid_i (i_req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   assign accept   = (state_q == ST_IDLE) && arb_any;
   assign sel_hart = i_req_hart[arb_idx];
   assign sel_file = i_req_file[arb_idx];
   assign sel_eiid = i_req_eiid[arb_idx];

   // Fields are widened before comparing so parameter values beyond the field range stay exact.
   assign req_legal = (32'(sel_hart) < NR_IMSICS)
                   && (32'(sel_file) < NR_INTP_FILES)
                   && (sel_eiid != '0)
                   && (32'(sel_eiid) < NR_SRC);

   // Harts are spaced by a block of file pages; files are consecutive pages within a hart.
   assign tgt_addr = AXI_ADDR_WIDTH'(IMSIC_BASE)
                   + (AXI_ADDR_WIDTH'(sel_hart) << (PAGE_SHIFT + INTP_FILE_LEN))
                   + (AXI_ADDR_WIDTH'(sel_file) << PAGE_SHIFT);

   // State register.
   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus watchdog; a wait stage that lasts TIMEOUT cycles is abandoned.
   always_comb begin
      state_d      = state_q;
      wdog_d       = wdog_q;
      fire_timeout = 1'b0;
      finish       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept && req_legal) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_BUSY;
            wdog_d  = '0;
         end
         ST_WAIT_BUSY: begin
            if (i_wr_busy) begin
               state_d = ST_WAIT_DONE;
               wdog_d  = '0;
            end else if (wdog_q == WD_LAST) begin
               state_d      = ST_IDLE;
               fire_timeout = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!i_wr_busy) begin
               state_d = ST_IDLE;
               finish  = 1'b1;
            end else if (wdog_q == WD_LAST) begin
               state_d      = ST_IDLE;
               fire_timeout = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; reset overrides the combinational ready as well.
   always_comb begin
      o_req_ready = '0;
      o_wr_start  = 1'b0;
      o_busy      = 1'b0;
      if (ni_rst) begin
         o_req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
         o_wr_start  = (state_q == ST_ISSUE);
         o_busy      = (state_q != ST_IDLE);
      end
   end

   // Datapath next values: pointer moves past every grantee, payload is captured only when legal.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      drop_d    = accept && !req_legal;
      timeout_d = fire_timeout;
      if (accept) begin
         rr_ptr_d = (32'(arb_idx) == NR_REQ - 1) ? '0 : arb_idx + 1'b1;
         if (req_legal) begin
            addr_d = tgt_addr;
            data_d = AXI_DATA_WIDTH'(sel_eiid);
         end
      end
      if (finish) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Datapath registers.
   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         rr_ptr_q  <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         wdog_q    <= '0;
         cnt_q     <= '0;
         drop_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         wdog_q    <= wdog_d;
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_wr_addr = addr_q;
   assign o_wr_data = data_q;
   assign o_drop    = drop_q;
   assign o_timeout = timeout_q;
   assign o_msi_cnt = cnt_q;

endmodule
